// File: rtl/pipe_ctrl_pkg.sv
// Shared pipeline-control definitions: forwarding codes for the EX-stage
// operand muxes and the destination-tag record carried down the shadow pipe.
package pipe_ctrl_pkg;

    localparam logic [1:0] FWD_REG = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b10;
    localparam logic [1:0] FWD_WB  = 2'b01;

    typedef struct packed {
        logic       valid;
        logic [4:0] dest;
        logic       regwrite;
        logic       memread;
    } hz_tag_t;

    localparam hz_tag_t TAG_NONE = '{valid: 1'b0, dest: 5'd0, regwrite: 1'b0, memread: 1'b0};

    // A stage can supply a source operand only if it really writes a
    // non-zero register equal to that source.
    function automatic logic producerHit(
        input logic       tagValid,
        input logic       tagRegWrite,
        input logic [4:0] tagDest,
        input logic [4:0] srcReg
    );
        return tagValid && tagRegWrite && (tagDest == srcReg) && (srcReg != 5'd0);
    endfunction

endpackage

// File: rtl/fwd_hazard_unit_fwd_match.sv
// Per-operand forwarding select: the nearer producer (EX, about to be in MEM)
// wins over the older one (MEM, about to be in WB).
module fwd_match
    import pipe_ctrl_pkg::*;
(
    input  logic       useSrc,
    input  logic [4:0] srcReg,
    input  logic       exValid,
    input  logic       exRegWrite,
    input  logic [4:0] exDest,
    input  logic       memValid,
    input  logic       memRegWrite,
    input  logic [4:0] memDest,
    output logic [1:0] fwdSel
);

    // Priority compare: MEM result first, then write-back data, else register file.
    always_comb begin
        fwdSel = FWD_REG;
        if (useSrc && producerHit(exValid, exRegWrite, exDest, srcReg)) begin
            fwdSel = FWD_MEM;
        end else if (useSrc && producerHit(memValid, memRegWrite, memDest, srcReg)) begin
            fwdSel = FWD_WB;
        end
    end

endmodule

// File: rtl/fwd_hazard_unit.sv
// Hazard detection and forwarding control for the 5-stage pipeline. Keeps a
// shadow EX/MEM/WB tag pipe, registers the ALU operand selects as the
// instruction enters EX, and raises stall/bubble/flush for load-use,
// mult/div busy and taken branches. MULDIV_CYCLES must lie in 2..15.
module fwd_hazard_unit
    import pipe_ctrl_pkg::*;
#(
    parameter int MULDIV_CYCLES = 4
)
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ID_Valid,
    input  logic [4:0] ID_Rs,
    input  logic [4:0] ID_Rt,
    input  logic       ID_UseRs,
    input  logic       ID_UseRt,
    input  logic [4:0] ID_Dest,
    input  logic       ID_RegWrite,
    input  logic       ID_MemRead,
    input  logic       ID_MulDiv,
    input  logic       ID_ReadsHiLo,
    input  logic       EX_BranchTaken,
    output logic [1:0] AluSrcA_Sel,
    output logic [1:0] AluSrcB_Sel,
    output logic       Stall_IF_ID,
    output logic       Bubble_ID_EX,
    output logic       Flush_IF_ID
);

    localparam logic [3:0] MD_RELOAD = 4'(MULDIV_CYCLES - 1);

    hz_tag_t    idTag;
    hz_tag_t    exTag;
    hz_tag_t    memTag;
    hz_tag_t    wbTag;
    logic [3:0] mdCount;
    logic       loadUse;
    logic       mdStall;
    logic       bubble;
    logic [1:0] selANext;
    logic [1:0] selBNext;
    logic       unusedTagBits;

    assign idTag = '{valid: ID_Valid, dest: ID_Dest, regwrite: ID_RegWrite, memread: ID_MemRead};

    // Hazard detection from the pre-edge EX tag and the busy counter.
    always_comb begin
        loadUse = 1'b0;
        if (ID_Valid && exTag.valid && exTag.memread && (exTag.dest != 5'd0)) begin
            loadUse = (ID_UseRs && (ID_Rs == exTag.dest)) ||
                      (ID_UseRt && (ID_Rt == exTag.dest));
        end
        mdStall = ID_Valid && (ID_MulDiv || ID_ReadsHiLo) && (mdCount != 4'd0);
    end

    // A taken branch kills the ID slot, so it bubbles but never holds IF/ID.
    assign bubble       = loadUse || mdStall || EX_BranchTaken;
    assign Bubble_ID_EX = bubble;
    assign Stall_IF_ID  = (loadUse || mdStall) && !EX_BranchTaken;
    assign Flush_IF_ID  = EX_BranchTaken;

    fwd_match uFwdA (
        .useSrc      (ID_UseRs),
        .srcReg      (ID_Rs),
        .exValid     (exTag.valid),
        .exRegWrite  (exTag.regwrite),
        .exDest      (exTag.dest),
        .memValid    (memTag.valid),
        .memRegWrite (memTag.regwrite),
        .memDest     (memTag.dest),
        .fwdSel      (selANext)
    );

    fwd_match uFwdB (
        .useSrc      (ID_UseRt),
        .srcReg      (ID_Rt),
        .exValid     (exTag.valid),
        .exRegWrite  (exTag.regwrite),
        .exDest      (exTag.dest),
        .memValid    (memTag.valid),
        .memRegWrite (memTag.regwrite),
        .memDest     (memTag.dest),
        .fwdSel      (selBNext)
    );

    // Shadow tag pipe: older stages always advance, EX takes ID or a bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exTag  <= TAG_NONE;
            memTag <= TAG_NONE;
            wbTag  <= TAG_NONE;
        end else begin
            wbTag  <= memTag;
            memTag <= exTag;
            exTag  <= bubble ? TAG_NONE : idTag;
        end
    end

    // Operand selects are captured as the instruction moves into EX.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            AluSrcA_Sel <= FWD_REG;
            AluSrcB_Sel <= FWD_REG;
        end else if (bubble) begin
            AluSrcA_Sel <= FWD_REG;
            AluSrcB_Sel <= FWD_REG;
        end else begin
            AluSrcA_Sel <= selANext;
            AluSrcB_Sel <= selBNext;
        end
    end

    // Mult/div busy down-counter; a flush leaves it alone since the op is past ID.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mdCount <= 4'd0;
        end else if (!bubble && ID_Valid && ID_MulDiv) begin
            mdCount <= MD_RELOAD;
        end else if (mdCount != 4'd0) begin
            mdCount <= mdCount - 4'd1;
        end
    end

    // WB tag and the older memread bit are carried for the operand muxes'
    // view of the pipe but do not feed any decision here.
    assign unusedTagBits = ^{wbTag, memTag.memread};

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Scoreboard bench for fwd_hazard_unit: a history-of-issued-instructions
// reference model predicts each cycle's outputs; a monitor compares them.
module tb_fwd_hazard_unit;

    localparam int MD = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ID_Valid = 1'b0;
    logic [4:0] ID_Rs = '0;
    logic [4:0] ID_Rt = '0;
    logic       ID_UseRs = 1'b0;
    logic       ID_UseRt = 1'b0;
    logic [4:0] ID_Dest = '0;
    logic       ID_RegWrite = 1'b0;
    logic       ID_MemRead = 1'b0;
    logic       ID_MulDiv = 1'b0;
    logic       ID_ReadsHiLo = 1'b0;
    logic       EX_BranchTaken = 1'b0;
    logic [1:0] AluSrcA_Sel;
    logic [1:0] AluSrcB_Sel;
    logic       Stall_IF_ID;
    logic       Bubble_ID_EX;
    logic       Flush_IF_ID;

    always #5 clk = ~clk;

    fwd_hazard_unit #(.MULDIV_CYCLES(MD)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .ID_Valid       (ID_Valid),
        .ID_Rs          (ID_Rs),
        .ID_Rt          (ID_Rt),
        .ID_UseRs       (ID_UseRs),
        .ID_UseRt       (ID_UseRt),
        .ID_Dest        (ID_Dest),
        .ID_RegWrite    (ID_RegWrite),
        .ID_MemRead     (ID_MemRead),
        .ID_MulDiv      (ID_MulDiv),
        .ID_ReadsHiLo   (ID_ReadsHiLo),
        .EX_BranchTaken (EX_BranchTaken),
        .AluSrcA_Sel    (AluSrcA_Sel),
        .AluSrcB_Sel    (AluSrcB_Sel),
        .Stall_IF_ID    (Stall_IF_ID),
        .Bubble_ID_EX   (Bubble_ID_EX),
        .Flush_IF_ID    (Flush_IF_ID)
    );

    typedef struct packed {
        bit       valid;
        bit [4:0] dest;
        bit       wr;
        bit       ld;
    } instr_t;

    typedef struct packed {
        logic [1:0]  selA;
        logic [1:0]  selB;
        logic        stall;
        logic        bubble;
        logic        flush;
        logic [31:0] cyc;
    } exp_t;

    exp_t       expQ[$];
    instr_t     inFlight[$];   // [0] = in EX, [1] = in MEM, [2] = in WB
    int         cycleNo;
    int         mdFreeAt;      // first ID cycle at which mult/div unit is idle
    logic [1:0] curSelA;
    logic [1:0] curSelB;
    int         checks = 0;
    int         errors = 0;
    event       sampleEv;

    function automatic logic [1:0] fwdFor(input bit useIt, input bit [4:0] r);
        if (!useIt || r == 5'd0) return 2'b00;
        if (inFlight[0].valid && inFlight[0].wr && inFlight[0].dest == r) return 2'b10;
        if (inFlight[1].valid && inFlight[1].wr && inFlight[1].dest == r) return 2'b01;
        return 2'b00;
    endfunction

    task automatic modelReset();
        inFlight.delete();
        repeat (3) inFlight.push_back('0);
        cycleNo  = 0;
        mdFreeAt = 0;
        curSelA  = 2'b00;
        curSelB  = 2'b00;
    endtask

    task automatic cmp(input string name, input logic [31:0] cyc,
                       input logic [1:0] got, input logic [1:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s cyc %0d got %b want %b", name, cyc, got, want);
        end
    endtask

    // Monitor: pops one expectation each time the stimulus marks a sample point.
    always begin : monitor
        exp_t e;
        @(sampleEv);
        if (expQ.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_empty got 0 entries want 1");
        end else begin
            e = expQ.pop_front();
            cmp("AluSrcA_Sel",  e.cyc, AluSrcA_Sel, e.selA);
            cmp("AluSrcB_Sel",  e.cyc, AluSrcB_Sel, e.selB);
            cmp("Stall_IF_ID",  e.cyc, {1'b0, Stall_IF_ID},  {1'b0, e.stall});
            cmp("Bubble_ID_EX", e.cyc, {1'b0, Bubble_ID_EX}, {1'b0, e.bubble});
            cmp("Flush_IF_ID",  e.cyc, {1'b0, Flush_IF_ID},  {1'b0, e.flush});
        end
    end

    task automatic pushZero();
        exp_t e;
        e = '0;
        e.cyc = cycleNo;
        expQ.push_back(e);
    endtask

    // One ID cycle: drive, predict, mark sample point, then advance the model.
    task automatic step(input bit v, input bit [4:0] rs, input bit [4:0] rt,
                        input bit ur, input bit urt, input bit [4:0] dest,
                        input bit wr, input bit ld, input bit md, input bit hilo,
                        input bit br, output bit stalled);
        instr_t ex;
        instr_t nw;
        bit     lu;
        bit     ms;
        bit     bub;
        exp_t   e;
        @(posedge clk);
        #1;
        ID_Valid = v;  ID_Rs = rs;  ID_Rt = rt;  ID_UseRs = ur;  ID_UseRt = urt;
        ID_Dest = dest;  ID_RegWrite = wr;  ID_MemRead = ld;  ID_MulDiv = md;
        ID_ReadsHiLo = hilo;  EX_BranchTaken = br;
        ex  = inFlight[0];
        lu  = v && ex.valid && ex.ld && ex.dest != 5'd0 &&
              ((ur && rs == ex.dest) || (urt && rt == ex.dest));
        ms  = v && (md || hilo) && (cycleNo < mdFreeAt);
        bub = lu || ms || br;
        e.selA   = curSelA;
        e.selB   = curSelB;
        e.stall  = (lu || ms) && !br;
        e.bubble = bub;
        e.flush  = br;
        e.cyc    = cycleNo;
        expQ.push_back(e);
        #3;
        ->sampleEv;
        curSelA = bub ? 2'b00 : fwdFor(ur, rs);
        curSelB = bub ? 2'b00 : fwdFor(urt, rt);
        if (!bub && v && md) mdFreeAt = cycleNo + MD;
        nw = '0;
        if (!bub) nw = '{valid: v, dest: dest, wr: wr, ld: ld};
        inFlight.push_front(nw);
        void'(inFlight.pop_back());
        cycleNo++;
        stalled = e.stall;
    endtask

    initial begin : stim
        bit s;
        int n;
        bit v, ur, urt, wr, ld, md, hilo, br;
        bit [4:0] rs, rt, dest;

        modelReset();
        #12;
        pushZero();
        ->sampleEv;
        @(negedge clk);
        rst_n = 1'b1;

        // add $3 ; sub $4,$3,$1 -> A from MEM
        step(1, 1, 2, 1, 1, 3, 1, 0, 0, 0, 0, s);
        step(1, 3, 1, 1, 1, 4, 1, 0, 0, 0, 0, s);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, s);
        // add $3 ; nop ; or $7,$1,$3 -> B from WB
        step(1, 1, 2, 1, 1, 3, 1, 0, 0, 0, 0, s);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, s);
        step(1, 1, 3, 1, 1, 7, 1, 0, 0, 0, 0, s);
        // write $0 then read $0
        step(1, 1, 2, 1, 1, 0, 1, 0, 0, 0, 0, s);
        step(1, 0, 0, 1, 1, 8, 1, 0, 0, 0, 0, s);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, s);
        // lw $5 ; add $6,$5,$5 held while stalled
        step(1, 1, 0, 1, 0, 5, 1, 1, 0, 0, 0, s);
        n = 0;
        do begin
            step(1, 5, 5, 1, 1, 6, 1, 0, 0, 0, 0, s);
            n++;
        end while (s && n < 6);
        // mult ; mflo held while stalled
        step(1, 8, 9, 1, 1, 0, 0, 0, 1, 0, 0, s);
        n = 0;
        do begin
            step(1, 0, 0, 0, 0, 10, 1, 0, 0, 1, 0, s);
            n++;
        end while (s && n < 8);
        // load-use coinciding with a taken branch
        step(1, 1, 0, 1, 0, 5, 1, 1, 0, 0, 0, s);
        step(1, 5, 2, 1, 1, 6, 1, 0, 0, 0, 1, s);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, s);
        // reset asserted in the middle of a load-use stall
        step(1, 1, 0, 1, 0, 5, 1, 1, 0, 0, 0, s);
        step(1, 5, 5, 1, 1, 6, 1, 0, 0, 0, 0, s);
        #2;
        rst_n = 1'b0;
        #1;
        modelReset();
        pushZero();
        ->sampleEv;
        @(negedge clk);
        rst_n = 1'b1;
        step(1, 5, 5, 1, 1, 6, 1, 0, 0, 0, 0, s);
        step(1, 6, 5, 1, 1, 7, 1, 0, 0, 0, 0, s);

        // random traffic; a stalled instruction is re-presented like a real pipe
        v = 0; rs = 0; rt = 0; ur = 0; urt = 0; dest = 0; wr = 0; ld = 0; md = 0; hilo = 0;
        s = 0;
        for (int i = 0; i < 2000; i++) begin
            if (!s || $urandom_range(0, 9) == 0) begin
                v    = ($urandom_range(0, 7) != 0);
                rs   = 5'($urandom_range(0, 3));
                rt   = 5'($urandom_range(0, 3));
                ur   = ($urandom_range(0, 3) != 0);
                urt  = ($urandom_range(0, 1) != 0);
                dest = 5'($urandom_range(0, 3));
                wr   = ($urandom_range(0, 3) != 0);
                ld   = ($urandom_range(0, 3) == 0);
                md   = ($urandom_range(0, 9) == 0);
                hilo = ($urandom_range(0, 9) == 0);
            end
            br = ($urandom_range(0, 19) == 0);
            step(v, rs, rt, ur, urt, dest, wr, ld, md, hilo, br, s);
        end

        #10;
        checks++;
        if (expQ.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got %0d entries want 0", expQ.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
